// File: rtl/pbus_arbiter.sv
// rtl/pbus_arbiter.sv - two-master arbiter, decoder and ACK/ERR generator for the 0xC00000 peripheral page
// Peripherals give no acknowledge; this block times every transfer with WAIT_CYCLES and answers for them.
module pbus_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int NSLV        = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         m0_adr,
  input  logic [7:0]          m0_dat_i,
  input  logic                m0_we,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  output logic [7:0]          m0_dat_o,
  output logic                m0_ack,
  output logic                m0_err,
  input  logic [10:0]         m1_adr,
  input  logic [7:0]          m1_dat_i,
  input  logic                m1_we,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  output logic [7:0]          m1_dat_o,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [10:0]         s_adr,
  output logic [7:0]          s_dat_o,
  output logic                s_we,
  output logic                s_cyc,
  output logic [NSLV-1:0]     s_stb,
  input  logic [8*NSLV-1:0]   s_dat_i,
  output logic [1:0]          owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, OWNED} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic       rr;
  logic [3:0] cnt;
  logic [2:0] slot_q;
  logic       hit_q;
  logic       we_q;
  logic       abort_q;

  logic        m0_req, m1_req, gnt_m1;
  logic [10:0] g_adr;
  logic        g_we;
  logic        own_cyc, own_stb, own_we;
  logic [10:0] own_adr;
  logic [7:0]  own_dat;
  logic        abort_now;
  logic [7:0]  cap_dat;
  logic [7:0]  rd_slot [8];

  function automatic logic dec_hit(input logic [10:0] a);
    return (a[10:8] == 3'd0) && (a[7:5] < 3'(NSLV));
  endfunction

  assign m0_req = m0_cyc & m0_stb;
  assign m1_req = m1_cyc & m1_stb;
  assign gnt_m1 = m1_req & (~m0_req | rr);
  assign g_adr  = gnt_m1 ? m1_adr : m0_adr;
  assign g_we   = gnt_m1 ? m1_we  : m0_we;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = 11'd0;
    own_dat = 8'd0;
    case (owner)
      2'b01: begin
        own_cyc = m0_cyc;
        own_stb = m0_stb;
        own_we  = m0_we;
        own_adr = m0_adr;
        own_dat = m0_dat_i;
      end
      2'b10: begin
        own_cyc = m1_cyc;
        own_stb = m1_stb;
        own_we  = m1_we;
        own_adr = m1_adr;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign s_adr   = own_adr;
  assign s_dat_o = own_dat;
  assign s_we    = own_we;
  assign s_cyc   = (owner != 2'b00);

  // Unused slot positions read as zero so the data mux never selects outside s_dat_i.
  for (genvar i = 0; i < 8; i++) begin : g_rd
    if (i < NSLV) begin : g_on
      assign rd_slot[i] = s_dat_i[8*i +: 8];
    end else begin : g_off
      assign rd_slot[i] = 8'h00;
    end
  end

  assign cap_dat   = (hit_q && !we_q) ? rd_slot[slot_q] : 8'h00;
  assign abort_now = abort_q | ~own_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'b00;
      rr       <= 1'b0;
      cnt      <= 4'd0;
      slot_q   <= 3'd0;
      hit_q    <= 1'b0;
      we_q     <= 1'b0;
      abort_q  <= 1'b0;
      s_stb    <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m0_dat_o <= 8'h00;
      m1_dat_o <= 8'h00;
    end else begin
      s_stb  <= '0;
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner   <= gnt_m1 ? 2'b10 : 2'b01;
            slot_q  <= g_adr[7:5];
            hit_q   <= dec_hit(g_adr);
            we_q    <= g_we;
            abort_q <= 1'b0;
            cnt     <= CNT_LOAD;
            if (dec_hit(g_adr)) s_stb <= NSLV'(1) << g_adr[7:5];
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // A cyc drop anywhere in ACCESS is remembered so the completion pulse is withheld.
          abort_q <= abort_now;
          if (cnt == 4'd0) begin
            if (owner == 2'b01) begin
              m0_dat_o <= cap_dat;
              m0_ack   <= ~abort_now & hit_q;
              m0_err   <= ~abort_now & ~hit_q;
            end else begin
              m1_dat_o <= cap_dat;
              m1_ack   <= ~abort_now & hit_q;
              m1_err   <= ~abort_now & ~hit_q;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (abort_q) begin
            owner <= 2'b00;
            rr    <= (owner == 2'b01);
            state <= IDLE;
          end else begin
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            owner <= 2'b00;
            rr    <= (owner == 2'b01);
            state <= IDLE;
          end else if (own_stb) begin
            slot_q  <= own_adr[7:5];
            hit_q   <= dec_hit(own_adr);
            we_q    <= own_we;
            abort_q <= 1'b0;
            cnt     <= CNT_LOAD;
            if (dec_hit(own_adr)) s_stb <= NSLV'(1) << own_adr[7:5];
            state   <= ACCESS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
